// File: rtl/imm_operand_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : imm_pkg
//  Brief    : Immediate type codes, opcode constants and the immediate former.
//  Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

    localparam logic [2:0] c_type_none    = 3'd0;
    localparam logic [2:0] c_type_itype   = 3'd1;
    localparam logic [2:0] c_type_stype   = 3'd2;
    localparam logic [2:0] c_type_sbtype  = 3'd3;
    localparam logic [2:0] c_type_utype   = 3'd4;
    localparam logic [2:0] c_type_ujtype  = 3'd5;
    localparam logic [2:0] c_type_csritype = 3'd6;
    localparam logic [2:0] c_type_illegal = 3'd7;

    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_system = 7'b1110011;
    localparam logic [6:0] c_op_reg    = 7'b0110011;

    // instr holds bits [31:7] of the instruction, so In[k] is instr[k-7].
    // The result is {illegal, imm64}; for xlen 32 the upper word is cleared.
    function automatic logic [64:0] imm_form(input logic [24:0] instr,
                                             input logic [2:0]  typ,
                                             input int          xlen);
        logic [63:0] imm;
        logic        illegal;
        imm     = '0;
        illegal = 1'b0;
        case (typ)
            c_type_itype:    imm = {{52{instr[24]}}, instr[24:13]};
            c_type_stype:    imm = {{52{instr[24]}}, instr[24:18], instr[4:0]};
            c_type_sbtype:   imm = {{51{instr[24]}}, instr[24], instr[0],
                                    instr[23:18], instr[4:1], 1'b0};
            c_type_utype:    imm = {{32{instr[24]}}, instr[24:5], 12'b0};
            c_type_ujtype:   imm = {{43{instr[24]}}, instr[24], instr[12:5],
                                    instr[13], instr[23:14], 1'b0};
            c_type_csritype: imm = {59'b0, instr[12:8]};
            c_type_illegal:  illegal = 1'b1;
            default:         imm = '0;
        endcase
        if (xlen == 32) begin
            imm[63:32] = '0;
        end
        return {illegal, imm};
    endfunction

    function automatic logic [2:0] imm_decode(input logic [6:0] opcode,
                                              input logic       funct3_msb);
        logic [2:0] typ;
        case (opcode)
            c_op_imm, c_op_load, c_op_jalr: typ = c_type_itype;
            c_op_store:                     typ = c_type_stype;
            c_op_branch:                    typ = c_type_sbtype;
            c_op_lui, c_op_auipc:           typ = c_type_utype;
            c_op_jal:                       typ = c_type_ujtype;
            c_op_system:                    typ = funct3_msb ? c_type_csritype : c_type_itype;
            c_op_reg:                       typ = c_type_none;
            default:                        typ = c_type_illegal;
        endcase
        return typ;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_operand_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : imm_operand_pipe_if
//  Brief    : Request/response handshake bundle of the immediate pipe.
//             Carries in_opcode only when IMM_AUTO_DECODE_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
interface imm_operand_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [24:0]      in_instr;
    logic [2:0]       in_type;
    logic [TAG_W-1:0] in_tag;
`ifdef IMM_AUTO_DECODE_EN
    logic [6:0]       in_opcode;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_illegal;

    modport master (
        output in_valid, in_instr, in_type, in_tag, out_ready,
`ifdef IMM_AUTO_DECODE_EN
        output in_opcode,
`endif
        input  in_ready, out_valid, out_imm, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_type, in_tag, out_ready,
`ifdef IMM_AUTO_DECODE_EN
        input  in_opcode,
`endif
        output in_ready, out_valid, out_imm, out_tag, out_illegal
    );

endinterface
`default_nettype wire

// File: rtl/imm_operand_pipe_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module   : imm_skid_buf
//  Brief    : Generic 2-entry valid/ready elastic buffer (output + skid reg).
//  Revision : 1.0 - initial release
// ============================================================================
module imm_skid_buf #(
    parameter int WIDTH = 38
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_flush,
    input  wire logic             i_valid,
    output logic                  o_ready,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  wire logic             i_ready,
    output logic      [WIDTH-1:0] o_data
);

    logic             r_or_valid;
    logic             r_sk_valid;
    logic [WIDTH-1:0] r_or_data;
    logic [WIDTH-1:0] r_sk_data;
    logic             w_push;
    logic             w_pop;

    // Ready depends only on the skid register, never on the consumer.
    assign o_ready = !r_sk_valid;
    assign w_push  = i_valid && !r_sk_valid;
    assign w_pop   = r_or_valid && i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
            r_or_data  <= '0;
            r_sk_data  <= '0;
        end else if (i_flush) begin
            r_or_valid <= 1'b0;
            r_sk_valid <= 1'b0;
        end else if (!r_or_valid || w_pop) begin
            if (r_sk_valid) begin
                r_or_valid <= 1'b1;
                r_or_data  <= r_sk_data;
                r_sk_valid <= 1'b0;
            end else begin
                r_or_valid <= w_push;
                if (w_push) begin
                    r_or_data <= i_data;
                end
            end
        end else if (w_push) begin
            r_sk_valid <= 1'b1;
            r_sk_data  <= i_data;
        end
    end

    assign o_valid = r_or_valid;
    assign o_data  = r_or_data;

endmodule
`default_nettype wire

// File: rtl/imm_operand_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : imm_operand_pipe
//  Brief    : Pipelined immediate generator with a 2-entry elastic output.
//             IMM_AUTO_DECODE_EN: derive the type from in_opcode.
//  Revision : 1.0 - initial release
// ============================================================================
module imm_operand_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         flush,
    imm_operand_pipe_if.slave bus
);

    localparam int c_pay_w = XLEN + TAG_W + 1;

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "imm_operand_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    logic [2:0]         w_type;
    logic [64:0]        w_form;
    logic [XLEN-1:0]    w_imm;
    logic               w_illegal;
    logic [c_pay_w-1:0] w_in_data;
    logic [c_pay_w-1:0] w_out_data;

`ifdef IMM_AUTO_DECODE_EN
    // funct3[2] is In[14], i.e. bit 7 of the [31:7] field.
    assign w_type = imm_decode(bus.in_opcode, bus.in_instr[7]);
`else
    assign w_type = bus.in_type;
`endif

    assign w_form    = imm_form(bus.in_instr, w_type, XLEN);
    assign w_imm     = XLEN'(w_form);
    assign w_illegal = w_form[64];
    assign w_in_data = {w_illegal, bus.in_tag, w_imm};

    imm_skid_buf #(
        .WIDTH (c_pay_w)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (bus.in_valid),
        .o_ready (bus.in_ready),
        .i_data  (w_in_data),
        .o_valid (bus.out_valid),
        .i_ready (bus.out_ready),
        .o_data  (w_out_data)
    );

    assign {bus.out_illegal, bus.out_tag, bus.out_imm} = w_out_data;

endmodule
`default_nettype wire

// File: tb/tb_imm_operand_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imm_operand_pipe
//  Brief    : Self-checking bench for imm_operand_pipe (XLEN 32 and 64).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imm_operand_pipe;

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    imm_operand_pipe_if #(.XLEN(32), .TAG_W(5)) bus32 ();
    imm_operand_pipe_if #(.XLEN(64), .TAG_W(5)) bus64 ();

    imm_operand_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
        .clk (clk), .rst (rst), .flush (flush), .bus (bus32)
    );
    imm_operand_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
        .clk (clk), .rst (rst), .flush (flush), .bus (bus64)
    );

    typedef struct {
        logic [31:0] word;
        logic [2:0]  typ;
        logic [4:0]  tag;
        logic [63:0] exp32;
        logic [63:0] exp64;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] word;
        logic [2:0]  typ;
        logic [4:0]  tag;
    } ent_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] w, input logic [2:0] t, input logic [4:0] tag);
        bus32.in_valid = v; bus32.in_instr = w[31:7]; bus32.in_type = t; bus32.in_tag = tag;
        bus64.in_valid = v; bus64.in_instr = w[31:7]; bus64.in_type = t; bus64.in_tag = tag;
    endtask

    task automatic setrdy(input logic r);
        bus32.out_ready = r;
        bus64.out_ready = r;
    endtask

    // Immediate computed from the full 32-bit word with signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] w, input logic [2:0] t, input int xlen);
        longint sw;
        longint r;
        sw = longint'($signed(w));
        r  = 0;
        case (t)
            3'd1: r = sw >>> 20;
            3'd2: r = ((sw >>> 25) <<< 5) | longint'(w[11:7]);
            3'd3: r = ((sw >>> 31) <<< 12) | (longint'(w[7]) << 11)
                      | (longint'(w[30:25]) << 5) | (longint'(w[11:8]) << 1);
            3'd4: r = (sw >>> 12) <<< 12;
            3'd5: r = ((sw >>> 31) <<< 20) | (longint'(w[19:12]) << 12)
                      | (longint'(w[20]) << 11) | (longint'(w[30:21]) << 1);
            3'd6: r = longint'(w[19:15]);
            default: r = 0;
        endcase
        if (xlen == 32) r = r & 64'h0000_0000_FFFF_FFFF;
        return r;
    endfunction

    vec_t vecs [10];
    ent_t q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hFFF00093, 3'd1, 5'd3,  64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[1] = '{32'hFE112E23, 3'd2, 5'd4,  64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[2] = '{32'hFF9FF06F, 3'd5, 5'd5,  64'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0};
        vecs[3] = '{32'h123450B7, 3'd4, 5'd6,  64'h1234_5000, 64'h0000_0000_1234_5000, 1'b0};
        vecs[4] = '{32'h800000B7, 3'd4, 5'd7,  64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0};
        vecs[5] = '{32'h000F8073, 3'd6, 5'd8,  64'h0000_001F, 64'h0000_0000_0000_001F, 1'b0};
        vecs[6] = '{32'hFFFFFFFF, 3'd7, 5'd9,  64'h0,         64'h0,                   1'b1};
        vecs[7] = '{32'hFFFFFFFF, 3'd0, 5'd10, 64'h0,         64'h0,                   1'b0};
        vecs[8] = '{32'hFE000EE3, 3'd3, 5'd11, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0};
        vecs[9] = '{32'h7FF00013, 3'd1, 5'd12, 64'h0000_07FF, 64'h0000_0000_0000_07FF, 1'b0};

        rst = 1'b1; flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        setrdy(1'b1);
        tick(); tick();
        chk("rst_out_valid", bus32.out_valid, 1'b0);
        chk("rst_in_ready", bus32.in_ready, 1'b1);
        chk("rst_out_imm32", bus32.out_imm, 64'h0);
        chk("rst_out_imm64", bus64.out_imm, 64'h0);
        chk("rst_out_tag", bus32.out_tag, 5'd0);
        chk("rst_out_illegal", bus32.out_illegal, 1'b0);
        rst = 1'b0;

        // Streaming vectors at one per cycle, checked one cycle after issue.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].word, vecs[i].typ, vecs[i].tag);
            tick();
            chk($sformatf("vec%0d_valid", i), bus32.out_valid, 1'b1);
            chk($sformatf("vec%0d_imm32", i), bus32.out_imm, vecs[i].exp32);
            chk($sformatf("vec%0d_imm64", i), bus64.out_imm, vecs[i].exp64);
            chk($sformatf("vec%0d_tag", i), bus32.out_tag, vecs[i].tag);
            chk($sformatf("vec%0d_illegal", i), bus32.out_illegal, vecs[i].ill);
        end
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        tick();
        chk("drain_out_valid", bus32.out_valid, 1'b0);

        // Back-pressure: A and B fill the buffer, C waits its turn.
        setrdy(1'b0);
        drive(1'b1, 32'h00500093, 3'd1, 5'd1);
        tick();
        chk("bp_a_in_ready", bus32.in_ready, 1'b1);
        chk("bp_a_imm", bus32.out_imm, 64'h5);
        drive(1'b1, 32'h00600093, 3'd1, 5'd2);
        tick();
        chk("bp_full_in_ready", bus32.in_ready, 1'b0);
        chk("bp_full_imm", bus32.out_imm, 64'h5);
        drive(1'b1, 32'h00700093, 3'd1, 5'd3);
        tick();
        chk("bp_c_in_ready", bus32.in_ready, 1'b0);
        chk("bp_hold_valid", bus32.out_valid, 1'b1);
        chk("bp_hold_tag", bus32.out_tag, 5'd1);
        setrdy(1'b1);
        tick();
        chk("bp_b_imm", bus32.out_imm, 64'h6);
        chk("bp_b_tag", bus32.out_tag, 5'd2);
        chk("bp_after_pop_ready", bus32.in_ready, 1'b1);
        tick();
        chk("bp_c_valid", bus32.out_valid, 1'b1);
        chk("bp_c_imm", bus32.out_imm, 64'h7);
        drive(1'b0, 32'h0, 3'd0, 5'd0);
        tick();
        chk("bp_empty", bus32.out_valid, 1'b0);

        // Flush, then reset, each with a full buffer and a live input.
        for (int k = 0; k < 2; k++) begin
            setrdy(1'b0);
            drive(1'b1, 32'h00100093, 3'd1, 5'd4);
            tick();
            drive(1'b1, 32'h00200093, 3'd1, 5'd5);
            tick();
            chk($sformatf("clr%0d_full", k), bus32.in_ready, 1'b0);
            drive(1'b1, 32'h00300093, 3'd1, 5'd6);
            if (k == 0) flush = 1'b1; else rst = 1'b1;
            tick();
            flush = 1'b0; rst = 1'b0;
            drive(1'b0, 32'h0, 3'd0, 5'd0);
            chk($sformatf("clr%0d_out_valid", k), bus32.out_valid, 1'b0);
            chk($sformatf("clr%0d_in_ready", k), bus32.in_ready, 1'b1);
            if (k == 1) chk("clr1_out_imm", bus32.out_imm, 64'h0);
            setrdy(1'b1);
            tick();
            chk($sformatf("clr%0d_dropped", k), bus32.out_valid, 1'b0);
        end

        // Randomised traffic against an ordered-queue model of the buffer.
        begin
            logic hold;
            logic v, r, f, acc, pop;
            logic [31:0] w;
            logic [2:0]  t;
            logic [4:0]  tg;
            hold = 1'b0; w = '0; t = '0; tg = '0;
            for (int n = 0; n < 3000; n++) begin
                chk("rnd_in_ready", bus32.in_ready, q.size() < 2);
                chk("rnd_valid32", bus32.out_valid, q.size() > 0);
                chk("rnd_valid64", bus64.out_valid, q.size() > 0);
                if (q.size() > 0) begin
                    chk("rnd_imm32", bus32.out_imm, ref_imm(q[0].word, q[0].typ, 32));
                    chk("rnd_imm64", bus64.out_imm, ref_imm(q[0].word, q[0].typ, 64));
                    chk("rnd_tag", bus32.out_tag, q[0].tag);
                    chk("rnd_illegal", bus64.out_illegal, q[0].typ == 3'd7);
                end
                if (!hold) begin
                    w  = $urandom;
                    t  = 3'($urandom_range(0, 7));
                    tg = 5'($urandom_range(0, 31));
                    v  = ($urandom_range(0, 3) != 0);
                end else begin
                    v = 1'b1;
                end
                r = ($urandom_range(0, 3) != 0);
                f = ($urandom_range(0, 63) == 0);
                drive(v, w, t, tg);
                setrdy(r);
                flush = f;
                acc = v && (q.size() < 2) && !f;
                pop = r && (q.size() > 0);
                tick();
                if (f) begin
                    q.delete();
                end else begin
                    if (pop) void'(q.pop_front());
                    if (acc) q.push_back('{w, t, tg});
                end
                hold = v && !acc && !f;
            end
            flush = 1'b0;
            drive(1'b0, 32'h0, 3'd0, 5'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
